// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state
// encodings, default geometry, length-field width and the per-state
// output decode used to keep the FSM outputs registered.
// Optional checksum trailer is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int AW_DEFAULT    = 6;
  localparam int LEN_W         = 16;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, LAST, CSUM, DONE, ERR
  } state_t;

  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic error;
    logic cpu_reset;
  } flags_t;

  // Output levels that hold while the FSM sits in state s.
  // CSUM still counts as a load in progress, so start stays ignored there.
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f.in_ready  = (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
    f.busy      = (s == LEN0) || (s == LEN1) || (s == DATA) || (s == LAST) || (s == CSUM);
    f.done      = (s == DONE);
    f.error     = (s == ERR);
    f.cpu_reset = (s != DONE);
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer. Keeps the three low lanes of the
// word in progress; the fourth byte is merged combinationally so the
// parent can register the complete word on the edge that accepts it.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] lanes;

  // Byte counter and lane capture; counter wraps 3->0 on the word's last byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= 2'd0;
      lanes <= '0;
    end else if (take) begin
      case (cnt)
        2'd0:    lanes[7:0]   <= data;
        2'd1:    lanes[15:8]  <= data;
        2'd2:    lanes[23:16] <= data;
        default: lanes        <= lanes;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

  assign word       = {data, lanes};
  assign word_valid = take && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Receives len_lo, len_hi and then
// len*4 bytes over valid/ready, writes packed words to the imem write
// port and releases the core reset once the program is complete.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_t           state;
  flags_t           flags;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len_full;
  logic             accept;
  logic             can_start;
  logic [31:0]      pk_word;
  logic             pk_word_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  assign accept    = in_valid && flags.in_ready;
  assign can_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign len_full  = {in_data, len[7:0]};

  assign in_ready  = flags.in_ready;
  assign busy      = flags.busy;
  assign done      = flags.done;
  assign error     = flags.error;
  assign cpu_reset = flags.cpu_reset;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (can_start),
    .take       (accept && (state == DATA)),
    .data       (in_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  // Load sequencer: state, length, word counter and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flags     <= flags_of(IDLE);
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      len       <= '0;
      word_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN0;
            flags    <= flags_of(LEN0);
            len      <= '0;
            word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= 8'd0;
`endif
          end
        end
        LEN0: begin
          if (accept) begin
            len[7:0] <= in_data;
            state    <= LEN1;
            flags    <= flags_of(LEN1);
          end
        end
        LEN1: begin
          if (accept) begin
            len <= len_full;
            if (len_full == '0) begin
              state <= DONE;
              flags <= flags_of(DONE);
            end else if (len_full > LEN_W'(DEPTH)) begin
              state <= ERR;
              flags <= flags_of(ERR);
            end else begin
              state <= DATA;
              flags <= flags_of(DATA);
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= sum + in_data;
`endif
            if (pk_word_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[AW-1:0];
              mem_wdata <= pk_word;
              word_cnt  <= word_cnt + LEN_W'(1);
              if (word_cnt == len - LEN_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CSUM;
                flags <= flags_of(CSUM);
`else
                state <= LAST;
                flags <= flags_of(LAST);
`endif
              end
            end
          end
        end
        LAST: begin
          state <= DONE;
          flags <= flags_of(DONE);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            if (in_data == sum) begin
              state <= DONE;
              flags <= flags_of(DONE);
            end else begin
              state <= ERR;
              flags <= flags_of(ERR);
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          flags <= flags_of(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (default DEPTH=64, AW=6).
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum trailer.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_reset, busy, done, error;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;

  int tests = 0;
  int fails = 0;
  int accepted = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  logic [7:0]  p1[10]    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  int          gtab[10]  = '{3, 0, 5, 1, 2, 0, 4, 1, 5, 2};
  logic [31:0] exp_d[2]  = '{32'h00000013, 32'h00100093};

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Record every write pulse and every handshake seen at the clock edge.
  always @(posedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (in_valid && in_ready) accepted++;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    accepted = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
    int n;
    in_valid = 1'b0;
    in_data  = 8'hA5;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL %s_timeout in_ready stayed 0 for 50 cycles", tag);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // After the last data byte of program 1: supply the trailer if needed,
  // leaving the bench one cycle after the transition into DONE.
  task automatic finish_prog1(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hB6, 0, tag);
`else
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset();
    tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL rst_cpu_reset got %0b want 1", cpu_reset); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %0b want 0", done); end
    tests++; if (busy !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rst_busy_error got %0b%0b want 00", busy, error); end
    tests++; if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 32'd0) begin
      fails++; $display("FAIL rst_port got we=%0b addr=%0d data=%h want 0 0 0", mem_we, mem_addr, mem_wdata); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL idle_hold got busy=%0b rdy=%0b want 0 0", busy, in_ready); end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    tests++; if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      fails++; $display("FAIL basic_len0 got busy=%0b rdy=%0b cr=%0b want 1 1 1", busy, in_ready, cpu_reset); end
    for (int i = 0; i < 10; i++) send_byte(p1[i], 0, "basic");
    tests++; if (mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_wdata !== 32'h00100093) begin
      fails++; $display("FAIL basic_lastwr got we=%0b addr=%0d data=%h want 1 1 00100093", mem_we, mem_addr, mem_wdata); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_early_done got %0b want 0", done); end
    finish_prog1("basic");
    tests++; if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done got done=%0b cr=%0b busy=%0b want 1 0 0", done, cpu_reset, busy); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL basic_we_after got %0b want 0", mem_we); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL basic_nwrites got %0d want 2", wa.size()); end
    else for (int i = 0; i < 2; i++) begin
      tests++; if (wa[i] !== 6'(i) || wd[i] !== exp_d[i]) begin
        fails++; $display("FAIL basic_wr%0d got %0d:%h want %0d:%h", i, wa[i], wd[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    tests++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL zero_restart got cr=%0b done=%0b want 1 0", cpu_reset, done); end
    send_byte(8'h00, 0, "zero");
    send_byte(8'h00, 0, "zero");
    tests++; if (done !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b0) begin
      fails++; $display("FAIL zero_done got done=%0b rdy=%0b cr=%0b want 1 0 0", done, in_ready, cpu_reset); end
    repeat (3) @(posedge clk); #1;
    tests++; if (wa.size() != 0) begin fails++; $display("FAIL zero_nwrites got %0d want 0", wa.size()); end
  endtask

  task automatic test_too_long();
    clear_log();
    pulse_start();
    send_byte(8'h41, 0, "long");
    send_byte(8'h00, 0, "long");
    tests++; if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL long_err got err=%0b rdy=%0b cr=%0b busy=%0b want 1 0 1 0", error, in_ready, cpu_reset, busy); end
    in_valid = 1'b1; in_data = 8'h13;
    repeat (4) @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (wa.size() != 0 || error !== 1'b1) begin fails++; $display("FAIL long_stuck got writes=%0d err=%0b want 0 1", wa.size(), error); end
    pulse_start();
    tests++; if (error !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL long_restart got err=%0b busy=%0b want 0 1", error, busy); end
    for (int i = 0; i < 10; i++) send_byte(p1[i], 0, "long");
    finish_prog1("long");
    tests++; if (done !== 1'b1 || wa.size() != 2) begin fails++; $display("FAIL long_reload got done=%0b writes=%0d want 1 2", done, wa.size()); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        pulse_start();
        tests++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
          fails++; $display("FAIL gap_start_ignored got busy=%0b rdy=%0b want 1 1", busy, in_ready); end
      end
      send_byte(p1[i], gtab[i], "gap");
    end
    finish_prog1("gap");
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL gap_done got %0b want 1", done); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    tests++; if (accepted != 11) begin fails++; $display("FAIL gap_accepted got %0d want 11", accepted); end
`else
    tests++; if (accepted != 10) begin fails++; $display("FAIL gap_accepted got %0d want 10", accepted); end
`endif
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL gap_nwrites got %0d want 2", wa.size()); end
    else for (int i = 0; i < 2; i++) begin
      tests++; if (wa[i] !== 6'(i) || wd[i] !== exp_d[i]) begin
        fails++; $display("FAIL gap_wr%0d got %0d:%h want %0d:%h", i, wa[i], wd[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(p1[i], 0, "mid");
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL mid_reset got busy=%0b cr=%0b rdy=%0b we=%0b want 0 1 0 0", busy, cpu_reset, in_ready, mem_we); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (wa.size() != 1) begin fails++; $display("FAIL mid_nwrites got %0d want 1", wa.size()); end
    else begin
      tests++; if (wa[0] !== 6'd0 || wd[0] !== 32'h00000013) begin
        fails++; $display("FAIL mid_wr0 got %0d:%h want 0:00000013", wa[0], wd[0]); end
    end
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(p1[i], 0, "mid");
    finish_prog1("mid");
    tests++; if (done !== 1'b1 || wa.size() != 2) begin fails++; $display("FAIL mid_reload got done=%0b writes=%0d want 1 2", done, wa.size()); end
    else begin
      tests++; if (wd[0] !== exp_d[0] || wd[1] !== exp_d[1]) begin
        fails++; $display("FAIL mid_reload_data got %h %h want %h %h", wd[0], wd[1], exp_d[0], exp_d[1]); end
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] b;
    clear_log();
    pulse_start();
    send_byte(8'h40, 0, "full");
    send_byte(8'h00, 0, "full");
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_byte(b, 0, "full");
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h80, 0, "full");
`else
    @(posedge clk); #1;
`endif
    tests++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL full_done got done=%0b err=%0b want 1 0", done, error); end
    tests++; if (wa.size() != 64) begin fails++; $display("FAIL full_nwrites got %0d want 64", wa.size()); end
    else begin
      tests++; if (wa[0] !== 6'd0 || wd[0] !== 32'h03020100) begin
        fails++; $display("FAIL full_first got %0d:%h want 0:03020100", wa[0], wd[0]); end
      tests++; if (wa[63] !== 6'd63 || wd[63] !== 32'hFFFEFDFC) begin
        fails++; $display("FAIL full_last got %0d:%h want 63:fffefdfc", wa[63], wd[63]); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_csum_bad();
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(p1[i], 0, "csum");
    tests++; if (in_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL csum_wait got rdy=%0b done=%0b want 1 0", in_ready, done); end
    send_byte(8'hB7, 0, "csum");
    tests++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL csum_err got err=%0b cr=%0b done=%0b want 1 1 0", error, cpu_reset, done); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL csum_nwrites got %0d want 2", wa.size()); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_back_to_back();
    test_reset_mid();
    test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_csum_bad();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: receives a length-prefixed byte stream over a valid/ready handshake.
- Packs the bytes little-endian into 32-bit words and drives a word-addressed write port on the instruction memory.
- Sits between a host byte source (UART receiver or testbench) and the imem write port.
- Holds the core in reset until a complete program has been written.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction memory.
- AW, 6, word-address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  byte-source data valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  imem write enable; one-cycle pulse per word.
- mem_addr  output  AW  word index being written.
- mem_wdata  output  32  assembled word.
- cpu_reset  output  1  core reset request; high except in DONE.
- busy  output  1  high in LEN0, LEN1, DATA and LAST.
- done  output  1  program loaded; high only in DONE.
- error  output  1  load rejected; high only in ERR.

Behaviour:
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, all counters=0.
- Byte accepted on a cycle with in_valid && in_ready. in_data is ignored otherwise.
- in_ready=1 only in LEN0, LEN1 and DATA (and CSUM when the optional feature is compiled in).
- Stream format: len_lo, len_hi (16-bit word count, little-endian), then len*4 data bytes.
- Within each word, byte k (k=0..3) maps to mem_wdata[8k+7:8k].

State machine:
- IDLE: start -> LEN0. Clear word counter and byte counter.
- LEN0: on accept, latch len[7:0] -> LEN1.
- LEN1: on accept, latch len[15:8]. Then:
  - len==0 -> DONE.
  - len>DEPTH -> ERR.
  - else -> DATA.
- DATA: a 2-bit byte counter wraps 3->0.
  - On accepting byte 3, the word is registered: next cycle mem_we=1, mem_addr=word counter, mem_wdata=word. The word counter then increments.
  - If that word is word len-1, state -> LAST and in_ready=0. Otherwise stay in DATA; in_ready stays 1, so byte acceptance overlaps the write pulse.
- LAST: mem_we=1 for this one cycle -> DONE next cycle.
- DONE: done=1, cpu_reset=0. start -> LEN0, and cpu_reset returns to 1 that same edge.
- ERR: error=1, cpu_reset=1, no writes. Exit only via start (-> LEN0) or reset.

Boundary conditions:
- start is ignored while busy.
- mem_we is never asserted outside DATA/LAST write cycles.
- The maximum address written is DEPTH-1; no wrap-around is possible because len>DEPTH is rejected.
- Reset mid-load: -> IDLE on the next edge, any pending write is dropped, cpu_reset=1. Words already written stay in memory.
- reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the final data byte, the next state is CSUM instead of LAST; the final word's mem_we pulse occurs on the first CSUM cycle.
  - CSUM accepts one trailing byte and compares it with the 8-bit modulo-256 sum of all data bytes.
  - Match -> DONE. Mismatch -> ERR; writes are already committed, but cpu_reset stays high.
  - len==0 still goes LEN1 -> DONE with no checksum byte.
- Without the macro: no CSUM state and no trailing byte.

Decomposition:
- Shared package/header imem_loader_pkg holds:
  - the state encodings IDLE, LEN0, LEN1, DATA, LAST, CSUM, DONE, ERR;
  - default DEPTH and AW;
  - the 16-bit length-field width.
- One sub-module, byte_packer:
  - 2-bit byte counter and 4-lane shift/assemble register;
  - outputs word and word_valid;
  - has its own clear input.
- The FSM, word counter and write-port register live in imem_loader.

Test Plan:
- After reset, check outputs: cpu_reset=1, in_ready=0, done=0. Then start + bytes 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, then addr1=0x00100093, one mem_we cycle each; done=1 and cpu_reset=0 one cycle after the last write.
- start + 00 00 -> DONE directly after LEN1, mem_we never asserted.
- start + 41 00 (len=65, DEPTH=64) -> error=1, in_ready=0, no writes. A subsequent start + a valid stream -> DONE.
- Repeat scenario 1 with in_valid randomly deasserted (gaps of 0-5 cycles) -> identical write sequence; no byte consumed while in_ready=0.
- Reset after 5 data bytes of a len=2 load -> IDLE next edge, busy=0, cpu_reset=1, only word 0 written. start plus a full stream reloads correctly.
- IMEM_LOADER_CHECKSUM_EN: scenario 1 plus trailing byte B6 -> DONE. Trailing byte B7 -> error=1, cpu_reset=1, both words still written.
